// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-arbiter state encoding.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    assign grant = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/axi4lite_write_arbiter.sv
// Shares one downstream AXI4-Lite write port between two upstream masters,
// one complete AW+W+B transaction at a time, round-robin on ties.
module axi4lite_write_arbiter
    import axi4lite_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s0_awvalid,
    output logic              s0_awready,
    input  logic [ADDR_W-1:0] s0_awaddr,
    input  logic [2:0]        s0_awprot,
    input  logic              s0_wvalid,
    output logic              s0_wready,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic [STRB_W-1:0] s0_wstrb,
    output logic              s0_bvalid,
    input  logic              s0_bready,
    output logic [1:0]        s0_bresp,
    input  logic              s1_awvalid,
    output logic              s1_awready,
    input  logic [ADDR_W-1:0] s1_awaddr,
    input  logic [2:0]        s1_awprot,
    input  logic              s1_wvalid,
    output logic              s1_wready,
    input  logic [DATA_W-1:0] s1_wdata,
    input  logic [STRB_W-1:0] s1_wstrb,
    output logic              s1_bvalid,
    input  logic              s1_bready,
    output logic [1:0]        s1_bresp,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp
);

    arb_state_e state_q;
    logic       g_q, last_q, aw_done_q, w_done_q;
    logic       aw_done_d, w_done_d;
    logic [1:0] req;
    logic       grant;
    logic       xfer, resp;

    logic              sg_awvalid, sg_wvalid, sg_bready;
    logic [ADDR_W-1:0] sg_awaddr;
    logic [2:0]        sg_awprot;
    logic [DATA_W-1:0] sg_wdata;
    logic [STRB_W-1:0] sg_wstrb;
    logic              awready_g, wready_g, bvalid_g;

    assign req = {s1_awvalid | s1_wvalid, s0_awvalid | s0_wvalid};

    rr_arb2 u_rr (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    assign xfer = (state_q == XFER);
    assign resp = (state_q == RESP);

    assign sg_awvalid = g_q ? s1_awvalid : s0_awvalid;
    assign sg_awaddr  = g_q ? s1_awaddr  : s0_awaddr;
    assign sg_awprot  = g_q ? s1_awprot  : s0_awprot;
    assign sg_wvalid  = g_q ? s1_wvalid  : s0_wvalid;
    assign sg_wdata   = g_q ? s1_wdata   : s0_wdata;
    assign sg_wstrb   = g_q ? s1_wstrb   : s0_wstrb;
    assign sg_bready  = g_q ? s1_bready  : s0_bready;

    // Payloads are zeroed outside XFER so nothing leaks downstream while idle or in reset.
    assign m_awvalid = xfer & sg_awvalid & ~aw_done_q;
    assign m_awaddr  = xfer ? sg_awaddr : '0;
    assign m_awprot  = xfer ? sg_awprot : '0;
    assign m_wvalid  = xfer & sg_wvalid & ~w_done_q;
    assign m_wdata   = xfer ? sg_wdata : '0;
    assign m_wstrb   = xfer ? sg_wstrb : '0;
    assign m_bready  = resp & sg_bready;

    assign awready_g  = xfer & m_awready & ~aw_done_q;
    assign wready_g   = xfer & m_wready & ~w_done_q;
    assign bvalid_g   = resp & m_bvalid;

    assign s0_awready = awready_g & ~g_q;
    assign s1_awready = awready_g & g_q;
    assign s0_wready  = wready_g & ~g_q;
    assign s1_wready  = wready_g & g_q;
    assign s0_bvalid  = bvalid_g & ~g_q;
    assign s1_bvalid  = bvalid_g & g_q;
    assign s0_bresp   = (resp & ~g_q) ? m_bresp : OKAY;
    assign s1_bresp   = (resp & g_q) ? m_bresp : OKAY;

    assign aw_done_d = aw_done_q | (m_awvalid & m_awready);
    assign w_done_d  = w_done_q | (m_wvalid & m_wready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        g_q     <= grant;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    // AW and W may complete in either order or together.
                    if (aw_done_d & w_done_d) begin
                        state_q   <= RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                RESP: begin
                    if (m_bvalid & m_bready) begin
                        last_q  <= g_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_write_arbiter.sv
// Scoreboard bench for axi4lite_write_arbiter: upstream masters and a downstream slave are modelled here.
module tb_axi4lite_write_arbiter;
    import axi4lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } txn_t;

    typedef struct {
        int          port;
        logic [31:0] v;
        logic [3:0]  x;
    } obs_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic              u_awvalid [2] = '{1'b0, 1'b0};
    logic              u_awready [2];
    logic [ADDR_W-1:0] u_awaddr  [2] = '{32'h0, 32'h0};
    logic [2:0]        u_awprot  [2] = '{3'h0, 3'h0};
    logic              u_wvalid  [2] = '{1'b0, 1'b0};
    logic              u_wready  [2];
    logic [DATA_W-1:0] u_wdata   [2] = '{32'h0, 32'h0};
    logic [STRB_W-1:0] u_wstrb   [2] = '{4'h0, 4'h0};
    logic              u_bvalid  [2];
    logic              u_bready  [2] = '{1'b1, 1'b1};
    logic [1:0]        u_bresp   [2];

    logic              m_awvalid, m_wvalid, m_bready;
    logic              m_awready = 1'b1;
    logic              m_wready  = 1'b1;
    logic              m_bvalid  = 1'b0;
    logic [1:0]        m_bresp   = 2'b00;
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;

    axi4lite_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_awvalid(u_awvalid[0]), .s0_awready(u_awready[0]), .s0_awaddr(u_awaddr[0]), .s0_awprot(u_awprot[0]),
        .s0_wvalid(u_wvalid[0]), .s0_wready(u_wready[0]), .s0_wdata(u_wdata[0]), .s0_wstrb(u_wstrb[0]),
        .s0_bvalid(u_bvalid[0]), .s0_bready(u_bready[0]), .s0_bresp(u_bresp[0]),
        .s1_awvalid(u_awvalid[1]), .s1_awready(u_awready[1]), .s1_awaddr(u_awaddr[1]), .s1_awprot(u_awprot[1]),
        .s1_wvalid(u_wvalid[1]), .s1_wready(u_wready[1]), .s1_wdata(u_wdata[1]), .s1_wstrb(u_wstrb[1]),
        .s1_bvalid(u_bvalid[1]), .s1_bready(u_bready[1]), .s1_bresp(u_bresp[1]),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Request counters (written by tests) versus issued counters (written by the driver).
    int aw_req [2] = '{0, 0};
    int w_req  [2] = '{0, 0};
    int aw_taken [2] = '{0, 0};
    int w_taken  [2] = '{0, 0};
    logic [1:0] slv_bresp = 2'b00;

    txn_t exp_q[$];
    obs_t obs_aw[$], obs_w[$], obs_b[$];
    int rd_aw = 0, rd_w = 0, rd_b = 0;

    bit aw_hs [2] = '{1'b0, 1'b0};
    bit w_hs  [2] = '{1'b0, 1'b0};
    bit mb_hs = 1'b0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    // Monitor: samples handshakes mid-cycle, away from the active edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; mb_hs = 1'b0;
            for (int p = 0; p < 2; p++) begin
                aw_hs[p] = 1'b0;
                w_hs[p]  = 1'b0;
            end
        end else begin
            mb_hs = m_bvalid && m_bready;
            if (mb_hs) b_cnt++;
            for (int p = 0; p < 2; p++) begin
                aw_hs[p] = u_awvalid[p] && u_awready[p];
                w_hs[p]  = u_wvalid[p] && u_wready[p];
                if (u_bvalid[p] && u_bready[p]) obs_b.push_back('{p, 32'(u_bresp[p]), 4'h0});
            end
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                obs_aw.push_back('{aw_hs[1] ? 1 : (aw_hs[0] ? 0 : -1), m_awaddr, {1'b0, m_awprot}});
            end
            if (m_wvalid && m_wready) begin
                w_cnt++;
                obs_w.push_back('{w_hs[1] ? 1 : (w_hs[0] ? 0 : -1), m_wdata, m_wstrb});
            end
        end
    end

    // Driver: upstream valids and the downstream slave's B channel, updated 1 time unit after the edge.
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            for (int p = 0; p < 2; p++) begin
                u_awvalid[p] = 1'b0;
                u_wvalid[p]  = 1'b0;
                aw_taken[p]  = aw_req[p];
                w_taken[p]   = w_req[p];
            end
            m_bvalid = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (aw_hs[p]) u_awvalid[p] = 1'b0;
                if (w_hs[p])  u_wvalid[p]  = 1'b0;
                if (!u_awvalid[p] && aw_req[p] != aw_taken[p]) begin
                    u_awvalid[p] = 1'b1;
                    aw_taken[p]++;
                end
                if (!u_wvalid[p] && w_req[p] != w_taken[p]) begin
                    u_wvalid[p] = 1'b1;
                    w_taken[p]++;
                end
            end
            if (mb_hs) m_bvalid = 1'b0;
            if (!m_bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
                m_bvalid = 1'b1;
                m_bresp  = slv_bresp;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #3;
        end
    endtask

    task automatic request(int p, logic [31:0] a, logic [2:0] pr, logic [31:0] d, logic [3:0] s,
                           logic [1:0] r, bit do_aw, bit do_w);
        u_awaddr[p] = a;
        u_awprot[p] = pr;
        u_wdata[p]  = d;
        u_wstrb[p]  = s;
        if (do_aw) aw_req[p]++;
        if (do_w)  w_req[p]++;
        exp_q.push_back('{p, a, pr, d, s, r});
    endtask

    task automatic wait_b(int n, int budget, output bit ok);
        while (obs_b.size() - rd_b < n && budget > 0) begin
            tick();
            budget--;
        end
        ok = (obs_b.size() - rd_b >= n);
    endtask

    function automatic logic [15:0] outs_vec();
        return {u_awready[0], u_wready[0], u_bvalid[0], u_awready[1], u_wready[1], u_bvalid[1],
                m_awvalid, m_wvalid, m_bready, |u_bresp[0], |u_bresp[1], |m_awaddr, |m_awprot,
                |m_wdata, |m_wstrb, 1'b0};
    endfunction

    task automatic flush();
        exp_q.delete();
        rd_aw = obs_aw.size();
        rd_w  = obs_w.size();
        rd_b  = obs_b.size();
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++;
        if (outs_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_during: outputs %h, want 0000", outs_vec());
        end
        aresetn = 1'b1;
        tick();
        n_cmp++;
        if (outs_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_after: outputs %h, want 0000", outs_vec());
        end
    endtask

    task automatic test_simultaneous();
        txn_t e; obs_t a, w, b; bit ok; int budget;
        slv_bresp = OKAY;
        request(0, 32'h0000_0100, 3'd0, 32'h1111_0000, 4'hF, OKAY, 1'b1, 1'b1);
        request(1, 32'h0000_0200, 3'd1, 32'h2222_0000, 4'h3, OKAY, 1'b1, 1'b1);
        budget = 20;
        while ((obs_aw.size() - rd_aw < 1 || obs_w.size() - rd_w < 1) && budget > 0) begin
            tick();
            budget--;
        end
        // s0 asks again while s1 is still waiting: s1 must win the next tie.
        request(0, 32'h0000_0104, 3'd2, 32'h3333_0000, 4'h1, OKAY, 1'b1, 1'b1);
        wait_b(3, 60, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL simul_timeout: got %0d responses, want 3", obs_b.size() - rd_b);
            flush();
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                a = obs_aw[rd_aw]; rd_aw++;
                w = obs_w[rd_w];   rd_w++;
                b = obs_b[rd_b];   rd_b++;
                n_cmp++;
                if (a.port !== e.port || a.v !== e.addr || a.x !== {1'b0, e.prot}) begin
                    n_fail++;
                    $display("FAIL simul_aw[%0d]: got port %0d addr %h prot %h, want port %0d addr %h prot %h",
                             i, a.port, a.v, a.x, e.port, e.addr, e.prot);
                end
                n_cmp++;
                if (w.port !== e.port || w.v !== e.data || w.x !== e.strb) begin
                    n_fail++;
                    $display("FAIL simul_w[%0d]: got port %0d data %h strb %h, want port %0d data %h strb %h",
                             i, w.port, w.v, w.x, e.port, e.data, e.strb);
                end
                n_cmp++;
                if (b.port !== e.port || b.v[1:0] !== e.resp) begin
                    n_fail++;
                    $display("FAIL simul_b[%0d]: got port %0d resp %h, want port %0d resp %h",
                             i, b.port, b.v[1:0], e.port, e.resp);
                end
            end
        end
    endtask

    task automatic test_single();
        txn_t e; obs_t a, w, b; int budget; bit s1_quiet;
        s1_quiet = 1'b1;
        tick(2);
        request(0, 32'h0000_0010, 3'd0, 32'hDEAD_BEEF, 4'hF, OKAY, 1'b1, 1'b1);
        budget = 30;
        while (obs_b.size() - rd_b < 1 && budget > 0) begin
            tick();
            budget--;
            if (u_awready[1] || u_wready[1] || u_bvalid[1] || u_bresp[1] !== OKAY) s1_quiet = 1'b0;
        end
        n_cmp++;
        if (!s1_quiet) begin
            n_fail++;
            $display("FAIL single_s1_quiet: s1 saw activity, want none");
        end
        n_cmp++;
        if (obs_b.size() - rd_b < 1) begin
            n_fail++;
            $display("FAIL single_timeout: got 0 responses, want 1");
            flush();
        end else begin
            e = exp_q.pop_front();
            a = obs_aw[rd_aw]; rd_aw++;
            w = obs_w[rd_w];   rd_w++;
            b = obs_b[rd_b];   rd_b++;
            n_cmp++;
            if (a.port !== 0 || a.v !== e.addr || w.v !== e.data || w.x !== e.strb) begin
                n_fail++;
                $display("FAIL single_payload: got port %0d addr %h data %h strb %h, want 0 %h %h %h",
                         a.port, a.v, w.v, w.x, e.addr, e.data, e.strb);
            end
            n_cmp++;
            if (b.port !== 0 || b.v[1:0] !== OKAY) begin
                n_fail++;
                $display("FAIL single_bresp: got port %0d resp %h, want port 0 resp 0", b.port, b.v[1:0]);
            end
        end
    endtask

    task automatic test_w_before_aw();
        txn_t e; obs_t a, w, b; bit ok; int aw0, w0;
        tick(2);
        aw0 = obs_aw.size();
        w0  = obs_w.size();
        m_awready = 1'b0;
        request(1, 32'h0000_0300, 3'd2, 32'hCAFE_F00D, 4'hC, OKAY, 1'b0, 1'b1);
        tick(3);
        aw_req[1]++;
        tick(3);
        n_cmp++;
        if (m_awvalid !== 1'b1 || u_bvalid[1] !== 1'b0 || m_bready !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_stall: got awvalid %b bvalid %b bready %b, want 1 0 0",
                     m_awvalid, u_bvalid[1], m_bready);
        end
        m_awready = 1'b1;
        wait_b(1, 30, ok);
        n_cmp++;
        if (obs_aw.size() - aw0 !== 1 || obs_w.size() - w0 !== 1) begin
            n_fail++;
            $display("FAIL wfirst_count: got %0d AW %0d W, want 1 1", obs_aw.size() - aw0, obs_w.size() - w0);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wfirst_timeout: got 0 responses, want 1");
            flush();
        end else begin
            e = exp_q.pop_front();
            a = obs_aw[rd_aw]; rd_aw++;
            w = obs_w[rd_w];   rd_w++;
            b = obs_b[rd_b];   rd_b++;
            n_cmp++;
            if (a.port !== 1 || a.v !== e.addr || a.x !== {1'b0, e.prot} || w.port !== 1 || w.v !== e.data) begin
                n_fail++;
                $display("FAIL wfirst_payload: got ports %0d/%0d addr %h data %h, want 1/1 %h %h",
                         a.port, w.port, a.v, w.v, e.addr, e.data);
            end
            n_cmp++;
            if (b.port !== 1 || b.v[1:0] !== OKAY) begin
                n_fail++;
                $display("FAIL wfirst_b: got port %0d resp %h, want port 1 resp 0", b.port, b.v[1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        txn_t e; obs_t b; bit ok; int budget;
        tick(2);
        slv_bresp   = SLVERR;
        u_bready[0] = 1'b0;
        request(0, 32'h0000_0040, 3'd5, 32'h0BAD_C0DE, 4'h5, SLVERR, 1'b1, 1'b1);
        budget = 20;
        while (u_bvalid[0] !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (u_bvalid[0] !== 1'b1 || u_bresp[0] !== SLVERR || m_bready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got bvalid %b bresp %h bready %b, want 1 2 0",
                         i, u_bvalid[0], u_bresp[0], m_bready);
            end
            tick();
        end
        u_bready[0] = 1'b1;
        wait_b(1, 10, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_timeout: got 0 responses, want 1");
            flush();
        end else begin
            e = exp_q.pop_front();
            rd_aw++;
            rd_w++;
            b = obs_b[rd_b]; rd_b++;
            n_cmp++;
            if (b.port !== 0 || b.v[1:0] !== e.resp) begin
                n_fail++;
                $display("FAIL bp_bresp: got port %0d resp %h, want port 0 resp %h", b.port, b.v[1:0], e.resp);
            end
            n_cmp++;
            if (outs_vec() !== 16'h0) begin
                n_fail++;
                $display("FAIL bp_idle: outputs %h, want 0000", outs_vec());
            end
        end
        slv_bresp = OKAY;
    endtask

    task automatic test_reset_mid();
        txn_t e; obs_t a, b; bit ok; int budget;
        tick(2);
        request(0, 32'h0000_0050, 3'd0, 32'h1234_5678, 4'hF, OKAY, 1'b1, 1'b0);
        budget = 20;
        while (obs_aw.size() - rd_aw < 1 && budget > 0) begin
            tick();
            budget--;
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (outs_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: outputs %h, want 0000", outs_vec());
        end
        tick(2);
        aresetn = 1'b1;
        void'(exp_q.pop_front());
        rd_aw = obs_aw.size();
        tick(3);
        n_cmp++;
        if (obs_b.size() !== rd_b) begin
            n_fail++;
            $display("FAIL rstmid_no_b: got %0d responses, want 0", obs_b.size() - rd_b);
            rd_b = obs_b.size();
        end
        request(0, 32'h0000_0060, 3'd1, 32'hA5A5_0001, 4'h1, OKAY, 1'b1, 1'b1);
        request(1, 32'h0000_0070, 3'd3, 32'h5A5A_0002, 4'h2, OKAY, 1'b1, 1'b1);
        wait_b(2, 40, ok);
        if (ok) begin
            request(1, 32'h0000_0080, 3'd4, 32'h0F0F_0003, 4'h8, OKAY, 1'b1, 1'b1);
            wait_b(3, 30, ok);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_timeout: got %0d responses, want 3", obs_b.size() - rd_b);
            flush();
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                a = obs_aw[rd_aw]; rd_aw++;
                rd_w++;
                b = obs_b[rd_b];   rd_b++;
                n_cmp++;
                if (a.port !== e.port || a.v !== e.addr || b.port !== e.port || b.v[1:0] !== e.resp) begin
                    n_fail++;
                    $display("FAIL rstmid_order[%0d]: got aw port %0d addr %h b port %0d, want port %0d addr %h",
                             i, a.port, a.v, b.port, e.port, e.addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_w_before_aw();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
